clock_lock_supervisor: RTL and testbench

Supervises the 49.152 MHz system clock domain after the crystal DLL chain. It holds the system reset until the second DLL reports stable lock, then releases it after a settle interval. It also measures the period of the recovered 48 kHz frame toggle against the local clock and flags it valid or invalid, so audio logic can switch between the crystal and recovered timing bases.

---
 rtl/clock_lock_supervisor_pkg.sv | 28 ++
 rtl/clock_lock_supervisor_if.sv | 24 ++
 rtl/clock_lock_sync.sv | 50 +++++
 rtl/clock_lock_supervisor.sv | 153 +++++++++++++++
 tb/tb_clock_lock_supervisor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/clock_lock_supervisor_pkg.sv
// Shared types and constants for the clock lock supervisor.
// Contents: FSM state enum, the 12-bit period type, the period saturation
// value, and the helper that judges a measured period against its window.
package clock_lock_supervisor_pkg;

  localparam int unsigned PERIOD_W = 12;

  typedef logic [PERIOD_W-1:0] period_t;

  localparam period_t PERIOD_SAT = 12'd4095;

  // FAULT is only reachable when CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN is defined.
  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_e;

  // True when |p - nominal| <= tol. Written without a subtraction so it
  // cannot underflow when nominal < tol.
  function automatic logic period_in_tol(input period_t p,
                                         input int unsigned nominal,
                                         input int unsigned tol);
    return ((32'(p) + tol) >= nominal) && (32'(p) <= (nominal + tol));
  endfunction

endpackage

// File: rtl/clock_lock_supervisor_if.sv
// Status bundle of the clock lock supervisor.
// master: the supervisor (takes dll_locked/frame_tgl, drives the status).
// slave : the environment (drives dll_locked/frame_tgl, reads the status).
interface clock_lock_supervisor_if;
  import clock_lock_supervisor_pkg::*;

  logic    dll_locked;
  logic    frame_tgl;
  logic    sys_rst_L;
  logic    rec_valid;
  period_t rec_period;
  logic    lock_lost;

  modport master (
    input  dll_locked, frame_tgl,
    output sys_rst_L, rec_valid, rec_period, lock_lost
  );

  modport slave (
    output dll_locked, frame_tgl,
    input  sys_rst_L, rec_valid, rec_period, lock_lost
  );

endinterface

// File: rtl/clock_lock_sync.sv
// Two-flop synchronizer with an optional registered rising-edge pulse.
// Ports: clk, ares_L (async active-low reset), d (async input),
//        q (synchronized level), rise (one-cycle pulse per rising edge of q,
//        tied low when EDGE_EN = 0).
module clock_lock_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic ares_L,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta;
  logic sync;

  // Metastability filter.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;

      // Third stage holds the previous level; the pulse itself is registered.
      always_ff @(posedge clk or negedge ares_L) begin
        if (!ares_L) begin
          prev <= 1'b0;
          rise <= 1'b0;
        end else begin
          prev <= sync;
          rise <= sync & ~prev;
        end
      end
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/clock_lock_supervisor.sv
// Clock lock supervisor: sequences the system reset from DLL lock and
// qualifies the recovered frame toggle by measuring its period in clk cycles.
// Ports: clk, ares_L (async active-low reset), bus (master modport:
//        dll_locked, frame_tgl in; sys_rst_L, rec_valid, rec_period,
//        lock_lost out, all registered).
// Build option: CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN makes a lock drop in
// RUN latch into FAULT until ares_L is asserted.
module clock_lock_supervisor
  import clock_lock_supervisor_pkg::*;
#(
  parameter int unsigned NOMINAL_PERIOD = 1024,
  parameter int unsigned TOLERANCE      = 8,
  parameter int unsigned GOOD_COUNT     = 4,
  parameter int unsigned SETTLE_CYCLES  = 4096
) (
  input  logic                    clk,
  input  logic                    ares_L,
  clock_lock_supervisor_if.master bus
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned GOOD_W   = (GOOD_COUNT > 1) ? $clog2(GOOD_COUNT + 1) : 1;
  localparam int unsigned TIMEOUT  = 2 * NOMINAL_PERIOD;

  state_e              state;
  state_e              next_state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                lock_s;
  logic                lock_rise_unused;
  logic                frame_s_unused;
  logic                frame_rise;
  logic                run_c;

  period_t             per_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  logic                first_edge;
  logic                sys_rst_q;
  logic                lock_lost_q;
  logic                rec_valid_q;
  period_t             rec_period_q;

  clock_lock_sync #(.EDGE_EN(1'b0)) u_lock_sync (
    .clk    (clk),
    .ares_L (ares_L),
    .d      (bus.dll_locked),
    .q      (lock_s),
    .rise   (lock_rise_unused)
  );

  clock_lock_sync #(.EDGE_EN(1'b1)) u_frame_sync (
    .clk    (clk),
    .ares_L (ares_L),
    .d      (bus.frame_tgl),
    .q      (frame_s_unused),
    .rise   (frame_rise)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      HOLD:    if (lock_s) next_state = SETTLE;
      SETTLE: begin
        if (!lock_s)                                          next_state = HOLD;
        else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1))  next_state = RUN;
      end
      RUN: begin
`ifdef CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN
        if (!lock_s) next_state = FAULT;
`else
        if (!lock_s) next_state = HOLD;
`endif
      end
`ifdef CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN
      FAULT:   next_state = FAULT;
`else
      FAULT:   next_state = HOLD;
`endif
      default: next_state = HOLD;
    endcase
  end

  // State register; the settle counter restarts whenever SETTLE is (re)entered.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      state      <= HOLD;
      settle_cnt <= '0;
    end else begin
      state      <= next_state;
      settle_cnt <= (state == SETTLE && next_state == SETTLE) ?
                    settle_cnt + SETTLE_W'(1) : '0;
    end
  end

  // Reset/lock outputs follow next_state so they line up with the transition edge.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      sys_rst_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sys_rst_q   <= (next_state == RUN);
      lock_lost_q <= (state == RUN) && (next_state != RUN);
    end
  end

  // Measurement is live only while staying in RUN; leaving RUN drops rec_valid.
  assign run_c = (state == RUN) && (next_state == RUN);

  // Period counter, good-period qualifier and timeout.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      per_cnt      <= '0;
      good_cnt     <= '0;
      first_edge   <= 1'b1;
      rec_valid_q  <= 1'b0;
      rec_period_q <= '0;
    end else if (!run_c) begin
      per_cnt     <= '0;
      good_cnt    <= '0;
      first_edge  <= 1'b1;
      rec_valid_q <= 1'b0;
    end else if (frame_rise) begin
      // Edge beats a coincident timeout.
      per_cnt    <= PERIOD_W'(1);
      first_edge <= 1'b0;
      if (!first_edge) begin
        rec_period_q <= per_cnt;
        if (period_in_tol(per_cnt, NOMINAL_PERIOD, TOLERANCE)) begin
          if (good_cnt != GOOD_W'(GOOD_COUNT)) good_cnt <= good_cnt + GOOD_W'(1);
          rec_valid_q <= (good_cnt >= GOOD_W'(GOOD_COUNT - 1));
        end else begin
          good_cnt    <= '0;
          rec_valid_q <= 1'b0;
        end
      end
    end else if (32'(per_cnt) == TIMEOUT) begin
      // Lost edges: requalify from scratch, next edge only reloads.
      good_cnt     <= '0;
      first_edge   <= 1'b1;
      rec_valid_q  <= 1'b0;
      rec_period_q <= PERIOD_SAT;
      if (per_cnt != PERIOD_SAT) per_cnt <= per_cnt + PERIOD_W'(1);
    end else if (per_cnt != PERIOD_SAT) begin
      per_cnt <= per_cnt + PERIOD_W'(1);
    end
  end

  assign bus.sys_rst_L  = sys_rst_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.rec_valid  = rec_valid_q;
  assign bus.rec_period = rec_period_q;

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Directed bench for clock_lock_supervisor with SETTLE_CYCLES = 16.
// Inputs change 1 ns after a rising clk edge; outputs are sampled there too.
module tb_clock_lock_supervisor;
  import clock_lock_supervisor_pkg::*;

`ifdef CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN
  localparam int EXP_LAST_PERIOD = 0;
`else
  localparam int EXP_LAST_PERIOD = 1024;
`endif

  logic clk;
  logic ares_L;
  int   checks;
  int   errors;

  clock_lock_supervisor_if bus ();

  clock_lock_supervisor #(
    .NOMINAL_PERIOD (1024),
    .TOLERANCE      (8),
    .GOOD_COUNT     (4),
    .SETTLE_CYCLES  (16)
  ) dut (
    .clk    (clk),
    .ares_L (ares_L),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // One frame_tgl period of p cycles with no checks.
  task automatic run_period(input int p);
    bus.frame_tgl = 1'b1;
    wait_cyc(p / 2);
    bus.frame_tgl = 1'b0;
    wait_cyc(p - p / 2);
  endtask

  // Rising edge, then check rec_valid one cycle before and rec_valid/rec_period
  // on the update cycle 4 clocks later; p is the spacing to the next rise.
  task automatic rise_and_check(input int p, input logic v_before, input logic v_after,
                                input int per_after, input string tag);
    bus.frame_tgl = 1'b1;
    wait_cyc(3);
    check({tag, "_valid_pre"}, 32'(bus.rec_valid), 32'(v_before));
    wait_cyc(1);
    check({tag, "_valid"}, 32'(bus.rec_valid), 32'(v_after));
    check({tag, "_period"}, 32'(bus.rec_period), 32'(per_after));
    wait_cyc(p / 2 - 4);
    bus.frame_tgl = 1'b0;
    wait_cyc(p - p / 2);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    ares_L         = 1'b0;
    bus.dll_locked = 1'b0;
    bus.frame_tgl  = 1'b0;

    // Reset values.
    wait_cyc(3);
    check("rst_sys_rst_L", 32'(bus.sys_rst_L), 32'd0);
    check("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check("rst_rec_period", 32'(bus.rec_period), 32'd0);
    check("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
    ares_L = 1'b1;
    wait_cyc(5);

    // Lock sequencing: sampled high at cycle 100 -> sys_rst_L high at cycle 119.
    bus.dll_locked = 1'b1;
    wait_cyc(18);
    check("lock_seq_pre", 32'(bus.sys_rst_L), 32'd0);
    wait_cyc(1);
    check("lock_seq_rise", 32'(bus.sys_rst_L), 32'd1);
    wait_cyc(10);

    // Nominal recovered clock: load edge + 4 good periods.
    rise_and_check(1024, 1'b0, 1'b0, 0,    "first_edge_load");
    rise_and_check(1024, 1'b0, 1'b0, 1024, "period_1024");
    run_period(1024);
    run_period(1024);
    rise_and_check(1040, 1'b0, 1'b1, 1024, "valid_after_4");

    // One 1040-cycle period is out of tolerance, then four 1020-cycle ones.
    rise_and_check(1020, 1'b1, 1'b0, 1040, "bad_1040");
    run_period(1020);
    run_period(1020);
    run_period(1020);
    rise_and_check(600, 1'b0, 1'b1, 1020, "revalid_1020");

    // Timeout: 2048 cycles after the last processed edge (edge at rise+4).
    wait_cyc(2051 - 600);
    check("timeout_pre_valid", 32'(bus.rec_valid), 32'd1);
    check("timeout_pre_period", 32'(bus.rec_period), 32'd1020);
    wait_cyc(1);
    check("timeout_valid", 32'(bus.rec_valid), 32'd0);
    check("timeout_period", 32'(bus.rec_period), 32'd4095);
    wait_cyc(100);

    // Resumed edges: first one only reloads the counter.
    rise_and_check(1024, 1'b0, 1'b0, 4095, "load_after_timeout");
    rise_and_check(1024, 1'b0, 1'b0, 1024, "resume_period");
    run_period(1024);
    run_period(1024);
    rise_and_check(300, 1'b0, 1'b1, 1024, "valid_again");

    // Lock loss in RUN: sys_rst_L low and lock_lost pulse 3 cycles later.
    bus.dll_locked = 1'b0;
    wait_cyc(2);
    check("loss_pre_sys_rst_L", 32'(bus.sys_rst_L), 32'd1);
    check("loss_pre_lock_lost", 32'(bus.lock_lost), 32'd0);
    wait_cyc(1);
    check("loss_sys_rst_L", 32'(bus.sys_rst_L), 32'd0);
    check("loss_lock_lost", 32'(bus.lock_lost), 32'd1);
    check("loss_rec_valid", 32'(bus.rec_valid), 32'd0);
    wait_cyc(1);
    check("loss_pulse_end", 32'(bus.lock_lost), 32'd0);
    wait_cyc(5);

`ifdef CLOCK_LOCK_SUPERVISOR_STICKY_FAULT_EN
    // Sticky fault: relock does not release reset until ares_L is pulsed.
    bus.dll_locked = 1'b1;
    wait_cyc(40);
    check("fault_sticky", 32'(bus.sys_rst_L), 32'd0);
    bus.dll_locked = 1'b0;
    ares_L = 1'b0;
    wait_cyc(2);
    ares_L = 1'b1;
    wait_cyc(2);
`else
    // Auto re-sequence after relock.
    bus.dll_locked = 1'b1;
    wait_cyc(18);
    check("relock_pre", 32'(bus.sys_rst_L), 32'd0);
    wait_cyc(1);
    check("relock_rise", 32'(bus.sys_rst_L), 32'd1);
    bus.dll_locked = 1'b0;
    wait_cyc(3);
    check("relock_drop_sys_rst_L", 32'(bus.sys_rst_L), 32'd0);
    check("relock_drop_lock_lost", 32'(bus.lock_lost), 32'd1);
    wait_cyc(5);
`endif

    // Mid-SETTLE glitch: 5 low cycles restart the settle count.
    bus.dll_locked = 1'b1;
    wait_cyc(8);
    bus.dll_locked = 1'b0;
    wait_cyc(5);
    bus.dll_locked = 1'b1;
    wait_cyc(6);
    check("glitch_no_early", 32'(bus.sys_rst_L), 32'd0);
    wait_cyc(12);
    check("glitch_pre", 32'(bus.sys_rst_L), 32'd0);
    wait_cyc(1);
    check("glitch_rise", 32'(bus.sys_rst_L), 32'd1);
    wait_cyc(3);
    check("pre_ares_period", 32'(bus.rec_period), 32'(EXP_LAST_PERIOD));

    // Asynchronous reset between clock edges.
    #3;
    ares_L = 1'b0;
    #1;
    check("ares_sys_rst_L", 32'(bus.sys_rst_L), 32'd0);
    check("ares_rec_period", 32'(bus.rec_period), 32'd0);
    check("ares_rec_valid", 32'(bus.rec_valid), 32'd0);
    check("ares_lock_lost", 32'(bus.lock_lost), 32'd0);
    wait_cyc(2);
    ares_L = 1'b1;
    wait_cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
